universal_register_n: RTL and testbench

- Parametrised successor to the 8-bit universal register used in the datapath.
- Features: WIDTH-bit register with hold, multi-bit right/left shift, rotate, increment, decrement, load and synchronous clear.
- Multi-bit shifts execute one bit per clock under a start/busy/done handshake. Carry and zero status feed the ALU/control unit.
- Serial ports chain registers for wider shifts.

---
 rtl/universal_register_n.sv | 146 ++++++++++++++
 tb/tb_universal_register_n.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_register_n.sv
// rtl/universal_register_n.sv - WIDTH-bit universal register with multi-cycle shift/rotate
// Single-cycle ops complete on the accepting edge; shifts/rotates step one bit per clock.
module universal_register_n #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   load_data,
  input  logic               serial_in_r,
  input  logic               serial_in_l,
  output logic [WIDTH-1:0]   q,
  output logic               serial_out_r,
  output logic               serial_out_l,
  output logic               busy,
  output logic               done,
  output logic               carry,
  output logic               zero
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_SHR  = 3'b001,
    OP_SHL  = 3'b010,
    OP_ROR  = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101,
    OP_LOAD = 3'b110,
    OP_CLR  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0]   reg_q, reg_d;
  logic               carry_q, carry_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      op_q    <= OP_HOLD;
      count_q <= '0;
      reg_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      count_q <= count_d;
      reg_q   <= reg_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    count_d = count_q;
    reg_d   = reg_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op_e'(op))
            OP_SHR, OP_SHL, OP_ROR: begin
              // A zero count behaves like hold: no RUN phase, immediate done.
              if (shamt == '0) begin
                done_d = 1'b1;
              end else begin
                op_d    = op_e'(op);
                count_d = shamt;
                state_d = RUN;
              end
            end
            OP_INC: begin
              {carry_d, reg_d} = {1'b0, reg_q} + {{WIDTH{1'b0}}, 1'b1};
              done_d = 1'b1;
            end
            OP_DEC: begin
              reg_d   = reg_q - {{(WIDTH-1){1'b0}}, 1'b1};
              carry_d = (reg_q == '0);
              done_d  = 1'b1;
            end
            OP_LOAD: begin
              reg_d   = load_data;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            OP_CLR: begin
              reg_d   = '0;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end
      RUN: begin
        case (op_q)
          OP_SHL: begin
            reg_d   = {reg_q[WIDTH-2:0], serial_in_l};
            carry_d = reg_q[WIDTH-1];
          end
          OP_ROR: begin
            reg_d   = {reg_q[0], reg_q[WIDTH-1:1]};
            carry_d = reg_q[0];
          end
          default: begin
            reg_d   = {serial_in_r, reg_q[WIDTH-1:1]};
            carry_d = reg_q[0];
          end
        endcase
        count_d = count_q - {{(SHAMT_W-1){1'b0}}, 1'b1};
        if (count_q == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign q            = reg_q;
  assign serial_out_r = reg_q[0];
  assign serial_out_l = reg_q[WIDTH-1];
  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign carry        = carry_q;
  assign zero         = (reg_q == '0);

endmodule

// File: tb/tb_universal_register_n.sv
// tb/tb_universal_register_n.sv - scoreboard bench for universal_register_n
// Stimulus pushes expected results; a negedge monitor pops them on every done pulse.
module tb_universal_register_n;

  logic       clk = 1'b0;
  logic       clr;
  logic       start;
  logic [2:0] op;
  logic [2:0] shamt;
  logic [7:0] load_data;
  logic       serial_in_r;
  logic       serial_in_l;
  logic [7:0] q;
  logic       serial_out_r;
  logic       serial_out_l;
  logic       busy;
  logic       done;
  logic       carry;
  logic       zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] q;
    logic       c;
  } exp_t;

  exp_t sb[$];

  universal_register_n #(.WIDTH(8), .SHAMT_W(3)) dut (
    .clk(clk), .clr(clr), .start(start), .op(op), .shamt(shamt),
    .load_data(load_data), .serial_in_r(serial_in_r), .serial_in_l(serial_in_l),
    .q(q), .serial_out_r(serial_out_r), .serial_out_l(serial_out_l),
    .busy(busy), .done(done), .carry(carry), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (clr === 1'b1 && done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("sb_q", q, e.q);
          check("sb_carry", carry, e.c);
          check("sb_zero", zero, (e.q == 8'h00));
          check("sb_serial_out", {serial_out_l, serial_out_r}, {e.q[7], e.q[0]});
        end
      end
    end
  end

  task automatic expect_res(input logic [7:0] eq, input logic ec);
    exp_t e;
    e.q = eq;
    e.c = ec;
    sb.push_back(e);
  endtask

  // Presents one start pulse; returns 1 time unit after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [2:0] s, input logic [7:0] ld,
                       input logic sir, input logic sil);
    start = 1'b1; op = o; shamt = s; load_data = ld; serial_in_r = sir; serial_in_l = sil;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 40 && busy; n++) begin
      @(posedge clk); #1;
    end
    if (busy) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_q"}, q, 8'h00);
    check({tag, "_zero"}, zero, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_carry"}, carry, 1'b0);
  endtask

  initial begin
    clr = 1'b0; start = 1'b0; op = 3'b000; shamt = 3'd0; load_data = 8'h00;
    serial_in_r = 1'b0; serial_in_l = 1'b0;
    #3;
    check_reset_state("por");
    #9 clr = 1'b1;
    @(posedge clk); #1;

    // Reset asserted between edges while a done pulse is showing
    expect_res(8'hFF, 1'b1);
    issue(3'b101, 3'd0, 8'h00, 1'b0, 1'b0);
    check("dec0_done", done, 1'b1);
    #2 clr = 1'b0;
    #1;
    check_reset_state("async");
    sb.delete();
    clr = 1'b1;
    @(posedge clk); #1;

    // Load and count
    expect_res(8'hA5, 1'b0);
    issue(3'b110, 3'd0, 8'hA5, 1'b0, 1'b0);
    check("load_busy", busy, 1'b0);
    check("load_done", done, 1'b1);
    @(posedge clk); #1;
    check("load_done_one_cycle", done, 1'b0);
    expect_res(8'hFF, 1'b0);
    issue(3'b110, 3'd0, 8'hFF, 1'b0, 1'b0);
    expect_res(8'h00, 1'b1);
    issue(3'b100, 3'd0, 8'h00, 1'b0, 1'b0);
    expect_res(8'hFF, 1'b1);
    issue(3'b101, 3'd0, 8'h00, 1'b0, 1'b0);
    expect_res(8'hFE, 1'b0);
    issue(3'b101, 3'd0, 8'h00, 1'b0, 1'b0);

    // Multi-cycle right shift with a load attempt while busy
    expect_res(8'h81, 1'b0);
    issue(3'b110, 3'd0, 8'h81, 1'b0, 1'b0);
    expect_res(8'hF0, 1'b0);
    issue(3'b001, 3'd3, 8'h00, 1'b1, 1'b0);
    check("shr_e0_busy", busy, 1'b1);
    check("shr_e0_q", q, 8'h81);
    start = 1'b1; op = 3'b110; load_data = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    check("shr_e1_q", q, 8'hC0);
    check("shr_e1_carry", carry, 1'b1);
    check("shr_e1_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("shr_e2_q", q, 8'hE0);
    check("shr_e2_busy", busy, 1'b1);
    @(posedge clk); #1;
    check("shr_e3_q", q, 8'hF0);
    check("shr_e3_busy", busy, 1'b0);
    check("shr_e3_done", done, 1'b1);
    @(posedge clk); #1;
    check("shr_done_one_cycle", done, 1'b0);

    // Rotate, left shift, zero count
    expect_res(8'h01, 1'b0);
    issue(3'b110, 3'd0, 8'h01, 1'b0, 1'b0);
    expect_res(8'h80, 1'b1);
    issue(3'b011, 3'd1, 8'h00, 1'b0, 1'b0);
    wait_idle();
    expect_res(8'h81, 1'b0);
    issue(3'b110, 3'd0, 8'h81, 1'b0, 1'b0);
    expect_res(8'h02, 1'b1);
    issue(3'b010, 3'd1, 8'h00, 1'b1, 1'b0);
    wait_idle();
    expect_res(8'h02, 1'b1);
    issue(3'b001, 3'd0, 8'h00, 1'b1, 1'b1);
    check("shamt0_busy", busy, 1'b0);
    check("shamt0_done", done, 1'b1);
    expect_res(8'h96, 1'b0);
    issue(3'b110, 3'd0, 8'h96, 1'b0, 1'b0);
    expect_res(8'h69, 1'b0);
    issue(3'b011, 3'd4, 8'h00, 1'b0, 1'b0);
    wait_idle();
    expect_res(8'h0F, 1'b0);
    issue(3'b110, 3'd0, 8'h0F, 1'b0, 1'b0);
    expect_res(8'h3F, 1'b0);
    issue(3'b010, 3'd2, 8'h00, 1'b0, 1'b1);
    wait_idle();
    expect_res(8'h3F, 1'b0);
    issue(3'b000, 3'd0, 8'h00, 1'b0, 1'b0);

    // Abort a shift with reset; no done must follow
    expect_res(8'hFF, 1'b0);
    issue(3'b110, 3'd0, 8'hFF, 1'b0, 1'b0);
    issue(3'b001, 3'd5, 8'h00, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_mid_q", q, 8'h3F);
    check("abort_mid_busy", busy, 1'b1);
    #2 clr = 1'b0;
    #1;
    check_reset_state("abort");
    clr = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    expect_res(8'h12, 1'b0);
    issue(3'b110, 3'd0, 8'h12, 1'b0, 1'b0);
    check("after_abort_q", q, 8'h12);

    // Back-to-back increments with start held high
    expect_res(8'h00, 1'b0);
    issue(3'b111, 3'd0, 8'h00, 1'b0, 1'b0);
    start = 1'b1; op = 3'b100;
    for (int i = 1; i <= 4; i++) begin
      expect_res(8'(i), 1'b0);
      @(posedge clk); #1;
      check("b2b_q", q, 8'(i));
      check("b2b_done", done, 1'b1);
    end
    start = 1'b0;

    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
